// File: rtl/sonic_dma_tx_ring_ctrl_if.sv
// Bundle of host-register, DMA-read and circular-buffer signals around the TX ring fetch controller.
// master = fetch controller, slave = surrounding host/DMA/buffer logic.
interface sonic_dma_tx_ring_ctrl_if #(
  parameter int RING_PTR_WIDTH = 16,
  parameter int CB_ADDR_WIDTH  = 9
);
  logic                      enable;
  logic [63:0]               ring_base;
  logic [RING_PTR_WIDTH-1:0] host_prod_ptr;
  logic                      host_prod_valid;
  logic [CB_ADDR_WIDTH:0]    cb_free_words;
  logic                      dma_req;
  logic [63:0]               dma_addr;
  logic [CB_ADDR_WIDTH:0]    dma_len;
  logic                      dma_ack;
  logic                      dma_done;
  logic [RING_PTR_WIDTH-1:0] cons_ptr;
  logic                      irq;
  logic                      busy;

  modport master (
    input  enable, ring_base, host_prod_ptr, host_prod_valid, cb_free_words,
           dma_ack, dma_done,
    output dma_req, dma_addr, dma_len, cons_ptr, irq, busy
  );

  modport slave (
    output enable, ring_base, host_prod_ptr, host_prod_valid, cb_free_words,
           dma_ack, dma_done,
    input  dma_req, dma_addr, dma_len, cons_ptr, irq, busy
  );
endinterface

// File: rtl/sonic_dma_tx_ring_ctrl.sv
// SoNIC TX ring fetch controller: issues non-wrapping DMA read bursts from the host ring into the TX buffer.
// Optional interrupt coalescing is compiled in with `define SONIC_TX_IRQ_COALESCE_EN.
//
// state     | meaning
// IDLE      | nothing pending, no buffer space, or disabled
// CALC      | size the next burst and register its host address
// REQ       | dma_req high, waiting for dma_ack
// WAIT_DONE | burst accepted, waiting for the last word to land
// COMMIT    | pointers advanced; chain into the next burst or go idle
module sonic_dma_tx_ring_ctrl #(
  parameter int RING_PTR_WIDTH = 16,
  parameter int CB_ADDR_WIDTH  = 9,
  parameter int MAX_BURST      = 32,
  parameter int IRQ_THRESH     = 256
) (
  input  logic                     clk_wr,
  input  logic                     rst,
  sonic_dma_tx_ring_ctrl_if.master bus
);
  localparam int RPW = RING_PTR_WIDTH;
  localparam int CLW = CB_ADDR_WIDTH + 1;
  localparam int LW  = (RPW + 1 > CLW) ? RPW + 1 : CLW;
  localparam logic [LW-1:0] MAX_B     = LW'(MAX_BURST);
  localparam logic [LW-1:0] RING_SIZE = LW'(1) << RPW;

  typedef enum logic [2:0] {IDLE, CALC, REQ, WAIT_DONE, COMMIT} state_t;

  state_t         state, state_nxt;
  logic [RPW-1:0] prod_q;
  logic [RPW-1:0] fetch_ptr;
  logic [RPW-1:0] pending;
  logic [RPW-1:0] burst_rp;
  logic [CLW-1:0] burst_q;
  logic [63:0]    addr_q;
  logic [LW-1:0]  pending_w, to_end_w, free_w, burst_nxt;
  logic           start_ok;
  logic           irq_q;

  assign pending   = prod_q - fetch_ptr;
  assign pending_w = LW'(pending);
  assign to_end_w  = RING_SIZE - LW'(fetch_ptr);
  assign free_w    = LW'(bus.cb_free_words);
  assign burst_rp  = RPW'(burst_q);
  assign start_ok  = bus.enable && (pending != '0) && (bus.cb_free_words != '0);

  always_comb begin
    burst_nxt = MAX_B;
    if (pending_w < burst_nxt) burst_nxt = pending_w;
    if (free_w    < burst_nxt) burst_nxt = free_w;
    if (to_end_w  < burst_nxt) burst_nxt = to_end_w;
  end

`ifdef SONIC_TX_IRQ_COALESCE_EN
  localparam int IW = $clog2(IRQ_THRESH + MAX_BURST + 1);
  logic [IW-1:0] irq_cnt, irq_sum, irq_cnt_nxt;
  logic          irq_fire;

  // Remainder after a threshold crossing carries over; an emptied ring flushes whatever is left.
  always_comb begin
    irq_sum     = irq_cnt + IW'(burst_q);
    irq_fire    = 1'b0;
    irq_cnt_nxt = irq_sum;
    if (irq_sum >= IW'(IRQ_THRESH)) begin
      irq_fire    = 1'b1;
      irq_cnt_nxt = irq_sum - IW'(IRQ_THRESH);
    end
    if (((fetch_ptr + burst_rp) == prod_q) && (irq_cnt_nxt != '0)) begin
      irq_fire    = 1'b1;
      irq_cnt_nxt = '0;
    end
  end
`endif

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start_ok) state_nxt = CALC;
      // Buffer space can vanish between the IDLE check and sizing; never issue a zero-length burst.
      CALC:      state_nxt = (burst_nxt != '0) ? REQ : IDLE;
      REQ:       if (bus.dma_ack) state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.dma_done) state_nxt = COMMIT;
      COMMIT:    state_nxt = start_ok ? CALC : IDLE;
      default:   state_nxt = IDLE;
    endcase
    bus.dma_req = (state == REQ);
    bus.busy    = (state != IDLE);
  end

  // Pointers move on the edge that sees dma_done so cons_ptr/irq are valid during COMMIT.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      prod_q    <= '0;
      fetch_ptr <= '0;
      burst_q   <= '0;
      addr_q    <= '0;
      irq_q     <= 1'b0;
`ifdef SONIC_TX_IRQ_COALESCE_EN
      irq_cnt   <= '0;
`endif
    end else begin
      irq_q <= 1'b0;
      if (bus.host_prod_valid) prod_q <= bus.host_prod_ptr;
      if (state == CALC) begin
        burst_q <= CLW'(burst_nxt);
        addr_q  <= bus.ring_base + 64'({fetch_ptr, 4'b0000});
      end
      if ((state == WAIT_DONE) && bus.dma_done) begin
        fetch_ptr <= fetch_ptr + burst_rp;
`ifdef SONIC_TX_IRQ_COALESCE_EN
        irq_q     <= irq_fire;
        irq_cnt   <= irq_cnt_nxt;
`else
        irq_q     <= 1'b1;
`endif
      end
    end
  end

  // Every fetched word is committed in the same cycle, so the consumer pointer is the fetch pointer.
  assign bus.cons_ptr = fetch_ptr;
  assign bus.dma_addr = addr_q;
  assign bus.dma_len  = burst_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_sonic_dma_tx_ring_ctrl.sv
// Self-checking bench for sonic_dma_tx_ring_ctrl: directed sequences, a vector table and random traffic
// checked by a burst-level ring model; honours SONIC_TX_IRQ_COALESCE_EN for the irq expectations.
module tb_sonic_dma_tx_ring_ctrl;
  localparam int RPW  = 16;
  localparam int CBW  = 9;
  localparam int MAXB = 32;
  localparam int THR  = 64;

  logic clk_wr = 1'b0;
  logic rst;
  always #5 clk_wr = ~clk_wr;

  sonic_dma_tx_ring_ctrl_if #(.RING_PTR_WIDTH(RPW), .CB_ADDR_WIDTH(CBW)) bus ();

  sonic_dma_tx_ring_ctrl #(
    .RING_PTR_WIDTH(RPW), .CB_ADDR_WIDTH(CBW), .MAX_BURST(MAXB), .IRQ_THRESH(THR)
  ) dut (
    .clk_wr(clk_wr),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk_wr) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  // DMA engine model
  bit resp_en = 1'b1;
  bit spur_en = 1'b0;
  int ack_min = 0, ack_max = 0, done_min = 0, done_max = 0;

  initial begin : responder
    int st, cnt;
    st = 0;
    cnt = 0;
    bus.dma_ack  = 1'b0;
    bus.dma_done = 1'b0;
    forever begin
      @(posedge clk_wr);
      #1;
      bus.dma_ack  = 1'b0;
      bus.dma_done = 1'b0;
      if (rst) st = 0;
      else begin
        case (st)
          0: if (bus.dma_req && resp_en) begin
               cnt = $urandom_range(ack_max, ack_min);
               if (cnt == 0) begin
                 bus.dma_ack = 1'b1;
                 cnt = $urandom_range(done_max, done_min);
                 st = 2;
               end else st = 1;
             end else if (!bus.dma_req && spur_en && ($urandom_range(7, 0) == 0)) begin
               bus.dma_done = 1'b1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin
                 bus.dma_ack = 1'b1;
                 cnt = $urandom_range(done_max, done_min);
                 st = 2;
               end
             end
          default: begin
               if (cnt == 0) begin
                 bus.dma_done = 1'b1;
                 st = 0;
               end else cnt--;
             end
        endcase
      end
    end
  end

  // Reference model: ring pointers and burst sizing rules, evaluated once per cycle at negedge
  logic [15:0] m_fetch, m_prodq, m_prodq_prev, cons_exp;
  logic [9:0]  m_free_prev;
  logic [63:0] cap_addr;
  logic [9:0]  cap_len;
  int          exp_len_m;
  bit          req_prev, in_flight, irq_exp;
  int          irq_acc, irq_pulses;
  logic [63:0] rq_addr[$];
  int          rq_len[$];
  int          rq_cyc[$];
  int          dn_cyc[$];

  initial begin : monitor
    logic [15:0] d;
    int lim;
    forever begin
      @(negedge clk_wr);
      if (rst) begin
        m_fetch = '0; m_prodq = '0; m_prodq_prev = '0; cons_exp = '0;
        m_free_prev = bus.cb_free_words;
        req_prev = 1'b0; in_flight = 1'b0; irq_exp = 1'b0; irq_acc = 0;
      end else begin
        check("cons_ptr", bus.cons_ptr, cons_exp);
        check("irq", bus.irq, irq_exp);
        irq_exp = 1'b0;
        if (bus.irq) irq_pulses++;
        if (bus.dma_req && !req_prev) begin
          d   = m_prodq_prev - m_fetch;
          lim = MAXB;
          if (int'(d) < lim) lim = int'(d);
          if (int'(m_free_prev) < lim) lim = int'(m_free_prev);
          if (65536 - int'(m_fetch) < lim) lim = 65536 - int'(m_fetch);
          exp_len_m = lim;
          check("req_len", bus.dma_len, lim);
          check("req_addr", bus.dma_addr, bus.ring_base + (64'(m_fetch) << 4));
          cap_addr = bus.dma_addr;
          cap_len  = bus.dma_len;
          rq_addr.push_back(bus.dma_addr);
          rq_len.push_back(int'(bus.dma_len));
          rq_cyc.push_back(cyc);
        end else if (bus.dma_req) begin
          check("req_addr_stable", bus.dma_addr, cap_addr);
          check("req_len_stable", bus.dma_len, cap_len);
        end
        if (in_flight && bus.dma_done) begin
          m_fetch = m_fetch + 16'(exp_len_m);
          cons_exp = m_fetch;
          in_flight = 1'b0;
          dn_cyc.push_back(cyc);
`ifdef SONIC_TX_IRQ_COALESCE_EN
          irq_acc += exp_len_m;
          if (irq_acc >= THR) begin
            irq_exp = 1'b1;
            irq_acc -= THR;
          end
          if ((m_fetch == m_prodq) && (irq_acc != 0)) begin
            irq_exp = 1'b1;
            irq_acc = 0;
          end
`else
          irq_exp = 1'b1;
`endif
        end
        if (bus.dma_req && bus.dma_ack) in_flight = 1'b1;
        req_prev = bus.dma_req;
        m_prodq_prev = m_prodq;
        if (bus.host_prod_valid) m_prodq = bus.host_prod_ptr;
        m_free_prev = bus.cb_free_words;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic clear_q();
    rq_addr.delete(); rq_len.delete(); rq_cyc.delete(); dn_cyc.delete();
    irq_pulses = 0;
  endtask

  task automatic strobe(input logic [15:0] p);
    bus.host_prod_ptr   = p;
    bus.host_prod_valid = 1'b1;
    tick();
    bus.host_prod_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.host_prod_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input logic [15:0] exp, input int budget, input string name);
    int i;
    i = 0;
    while (i < budget && !(!bus.busy && bus.cons_ptr == exp)) begin
      tick();
      i++;
    end
    check({name, "_cons"}, bus.cons_ptr, exp);
    check({name, "_busy"}, bus.busy, 1'b0);
  endtask

  task automatic wait_req(input int budget, input string name);
    int i;
    i = 0;
    while (i < budget && !bus.dma_req) begin
      tick();
      i++;
    end
    check({name, "_req"}, bus.dma_req, 1'b1);
  endtask

  typedef struct {
    int adv;
    int free;
    int n;
    int len0;
    int lenl;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] tb_prod;
  int          exp_l[4];
  int          r;

  initial begin
    vecs[0] = '{adv: 10,  free: 512, n: 1, len0: 10, lenl: 10};
    vecs[1] = '{adv: 100, free: 512, n: 4, len0: 32, lenl: 4};
    vecs[2] = '{adv: 5,   free: 3,   n: 2, len0: 3,  lenl: 2};
    vecs[3] = '{adv: 33,  free: 512, n: 2, len0: 32, lenl: 1};
    vecs[4] = '{adv: 1,   free: 1,   n: 1, len0: 1,  lenl: 1};
    vecs[5] = '{adv: 64,  free: 16,  n: 4, len0: 16, lenl: 16};
    vecs[6] = '{adv: 40,  free: 7,   n: 6, len0: 7,  lenl: 5};
    exp_l   = '{32, 32, 32, 4};

    rst = 1'b1;
    bus.enable = 1'b0; bus.ring_base = '0; bus.host_prod_ptr = '0;
    bus.host_prod_valid = 1'b0; bus.cb_free_words = '0;
    irq_pulses = 0;
    repeat (3) tick();
    check("rst_dma_req", bus.dma_req, 1'b0);
    check("rst_dma_addr", bus.dma_addr, 64'h0);
    check("rst_dma_len", bus.dma_len, 0);
    check("rst_cons_ptr", bus.cons_ptr, 0);
    check("rst_irq", bus.irq, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    tick();

    // Single burst with request latency
    bus.ring_base = 64'h1000; bus.cb_free_words = 10'd512; bus.enable = 1'b1;
    tick();
    clear_q();
    strobe(16'd10);
    check("lat_busy_n1", bus.busy, 1'b0);
    tick();
    check("lat_busy_n2", bus.busy, 1'b1);
    check("lat_req_n2", bus.dma_req, 1'b0);
    tick();
    check("lat_req_n3", bus.dma_req, 1'b1);
    check("single_addr", bus.dma_addr, 64'h1000);
    check("single_len", bus.dma_len, 10);
    tick();
    check("req_drop_after_ack", bus.dma_req, 1'b0);
    wait_idle(16'd10, 50, "single");
    check("single_irq_pulses", irq_pulses, 1);

    // Burst splitting and back-to-back spacing
    do_reset();
    bus.ring_base = '0;
    clear_q();
    strobe(16'd100);
    wait_idle(16'd100, 400, "split");
    check("split_nreq", rq_len.size(), 4);
    for (int i = 0; i < 4 && i < rq_len.size(); i++) begin
      check("split_len", rq_len[i], exp_l[i]);
      check("split_addr", rq_addr[i], 64'(i) * 64'h200);
    end
    for (int i = 0; i < 3 && i + 1 < rq_cyc.size() && i < dn_cyc.size(); i++)
      check("split_gap", rq_cyc[i+1] - dn_cyc[i], 3);
`ifdef SONIC_TX_IRQ_COALESCE_EN
    check("split_irq_pulses", irq_pulses, 2);
`else
    check("split_irq_pulses", irq_pulses, 4);
`endif

    // Vector table
    do_reset();
    bus.ring_base = {32'($urandom), 28'($urandom), 4'h0};
    tb_prod = '0;
    foreach (vecs[k]) begin
      bus.cb_free_words = 10'(vecs[k].free);
      clear_q();
      tb_prod = tb_prod + 16'(vecs[k].adv);
      strobe(tb_prod);
      wait_idle(tb_prod, 2000, "vec");
      check("vec_nreq", rq_len.size(), vecs[k].n);
      if (rq_len.size() > 0) begin
        check("vec_len0", rq_len[0], vecs[k].len0);
        check("vec_lenlast", rq_len[rq_len.size()-1], vecs[k].lenl);
      end
    end

    // Backpressure
    clear_q();
    bus.cb_free_words = 10'd5;
    tb_prod = tb_prod + 16'd20;
    strobe(tb_prod);
    wait_req(20, "bp");
    check("bp_len", bus.dma_len, 5);
    bus.cb_free_words = '0;
    repeat (20) tick();
    check("bp_nreq_stalled", rq_len.size(), 1);
    check("bp_busy_stalled", bus.busy, 1'b0);
    check("bp_cons_stalled", bus.cons_ptr, tb_prod - 16'd15);
    bus.cb_free_words = 10'd512;
    wait_idle(tb_prod, 100, "bp_resume");
    check("bp_nreq", rq_len.size(), 2);
    if (rq_len.size() > 1) check("bp_len2", rq_len[1], 15);

    // Enable dropped during WAIT_DONE
    done_min = 5; done_max = 5;
    clear_q();
    tb_prod = tb_prod + 16'd50;
    strobe(tb_prod);
    wait_req(20, "dis");
    tick();
    check("dis_in_wait_req", bus.dma_req, 1'b0);
    check("dis_in_wait_busy", bus.busy, 1'b1);
    bus.enable = 1'b0;
    wait_idle(tb_prod - 16'd18, 50, "dis");
    repeat (5) tick();
    check("dis_nreq", rq_len.size(), 1);
    check("dis_busy", bus.busy, 1'b0);
    check("dis_cons_held", bus.cons_ptr, tb_prod - 16'd18);
    bus.enable = 1'b1;
    done_min = 0; done_max = 0;
    wait_idle(tb_prod, 200, "reenable");

    // Reset during REQ
    ack_min = 4; ack_max = 4;
    tb_prod = tb_prod + 16'd10;
    strobe(tb_prod);
    wait_req(20, "rstreq");
    rst = 1'b1;
    #1;
    check("rstreq_dma_req", bus.dma_req, 1'b0);
    check("rstreq_dma_addr", bus.dma_addr, 64'h0);
    check("rstreq_dma_len", bus.dma_len, 0);
    check("rstreq_cons", bus.cons_ptr, 0);
    check("rstreq_busy", bus.busy, 1'b0);
    check("rstreq_irq", bus.irq, 1'b0);
    tick();
    rst = 1'b0;
    ack_min = 0; ack_max = 0;
    tick();

    // Ring wrap
    bus.ring_base = 64'h0010_0000;
    bus.cb_free_words = 10'd512;
    strobe(16'd65530);
    wait_idle(16'd65530, 20000, "wrap_fill");
    clear_q();
    strobe(16'd4);
    wait_idle(16'd4, 100, "wrap");
    check("wrap_nreq", rq_len.size(), 2);
    if (rq_len.size() > 1) begin
      check("wrap_len0", rq_len[0], 6);
      check("wrap_addr0", rq_addr[0], 64'h0010_0000 + 64'hFFFA0);
      check("wrap_len1", rq_len[1], 4);
      check("wrap_addr1", rq_addr[1], 64'h0010_0000);
    end

    // Random traffic against the model
    do_reset();
    bus.ring_base = {32'($urandom), 28'($urandom), 4'h0};
    tb_prod = '0;
    spur_en = 1'b1;
    ack_max = 3; done_max = 3;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(15, 0) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(7, 0) == 0) begin
        r = $urandom_range(3, 0);
        if (r == 0)      bus.cb_free_words = '0;
        else if (r == 1) bus.cb_free_words = 10'($urandom_range(8, 1));
        else             bus.cb_free_words = 10'($urandom_range(512, 1));
      end
      if (($urandom_range(5, 0) == 0) && (16'(tb_prod - m_fetch) < 16'd60000)) begin
        tb_prod = tb_prod + 16'($urandom_range(70, 0));
        bus.host_prod_ptr   = tb_prod;
        bus.host_prod_valid = 1'b1;
      end else bus.host_prod_valid = 1'b0;
      tick();
    end
    bus.host_prod_valid = 1'b0;
    bus.enable = 1'b1;
    bus.cb_free_words = 10'd512;
    spur_en = 1'b0;
    wait_idle(tb_prod, 5000, "rand_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
